// File: rtl/avst_pkt_tx.sv
// Avalon-ST store-and-forward packet source: bytes + last flag in, whole packets out under ready backpressure.
// Optional AVST_TX_STATS_EN adds a 16-bit count of transmitted packets (tx_pkt_cnt).
module avst_pkt_tx #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_full,
   output logic [DATA_W-1:0] data_out,
   output logic              end_out,
   output logic              valid_out,
   input  logic              ready_out
`ifdef AVST_TX_STATS_EN
   ,
   output logic [15:0]       tx_pkt_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(DEPTH + 2);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t            state, state_nxt;
   logic [DATA_W:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [PW-1:0]     pkt_cnt;
   logic [7:0]        gap_cnt, gap_cnt_nxt;
   logic              push, pop, xfer, end_xfer, fifo_empty, start_ok, out_vld_nxt;

   assign wr_full    = (count == CW'(DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = wr_en & ~wr_full;
   assign xfer       = valid_out & ready_out;
   assign end_xfer   = xfer & end_out;
   // A full FIFO with no complete packet would deadlock, so it is allowed to start (cut-through).
   assign start_ok   = (pkt_cnt != '0) | wr_full;

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      out_vld_nxt = valid_out;
      gap_cnt_nxt = gap_cnt;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = SEND;
         end
         SEND: begin
            if (end_xfer) begin
               if (GAP_CYCLES > 0) begin
                  state_nxt   = GAP;
                  gap_cnt_nxt = 8'(GAP_CYCLES);
                  out_vld_nxt = 1'b0;
               end else if (pkt_cnt > PW'(1)) begin
                  pop         = 1'b1;
                  out_vld_nxt = 1'b1;
               end else begin
                  state_nxt   = IDLE;
                  out_vld_nxt = 1'b0;
               end
            end else if (!valid_out || xfer) begin
               // A held last beat never reaches here, so nothing past it is popped.
               pop         = ~fifo_empty;
               out_vld_nxt = ~fifo_empty;
            end
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt - 8'd1;
            if (gap_cnt == 8'd1) begin
               // Load the next head on the exit edge so the idle stretch is exactly GAP_CYCLES.
               if (start_ok) begin
                  state_nxt   = SEND;
                  pop         = 1'b1;
                  out_vld_nxt = 1'b1;
               end else begin
                  state_nxt   = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkt_cnt   <= '0;
         valid_out <= 1'b0;
         end_out   <= 1'b0;
         data_out  <= '0;
      end else begin
         state     <= state_nxt;
         gap_cnt   <= gap_cnt_nxt;
         valid_out <= out_vld_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if ((push & wr_last) & ~end_xfer)      pkt_cnt <= pkt_cnt + 1'b1;
         else if (~(push & wr_last) & end_xfer) pkt_cnt <= pkt_cnt - 1'b1;
         if (pop) {end_out, data_out} <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_last, wr_data};
   end

`ifdef AVST_TX_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        tx_pkt_cnt <= '0;
      else if (end_xfer) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_avst_pkt_tx.sv
// Bench for avst_pkt_tx: directed timing steps plus randomized packets checked against an in-order stream model.
module tb_avst_pkt_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en, wr_last, wr_full, end_out, valid_out, ready_out;
   logic [7:0] wr_data, data_out;
   logic       b_wr_en, b_wr_last, b_wr_full, b_end_out, b_valid_out, b_ready_out;
   logic [7:0] b_wr_data, b_data_out;
`ifdef AVST_TX_STATS_EN
   logic [15:0] tx_cnt, b_tx_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Model: the transmitted stream equals the accepted write stream, in order, minus what reset drops.
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   logic       hold_pend;
   logic [8:0] held;

   always #5 clk = ~clk;

   avst_pkt_tx #(.DATA_W(8), .DEPTH(16), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
      .wr_full(wr_full), .data_out(data_out), .end_out(end_out), .valid_out(valid_out),
      .ready_out(ready_out)
`ifdef AVST_TX_STATS_EN
      , .tx_pkt_cnt(tx_cnt)
`endif
   );

   avst_pkt_tx #(.DATA_W(8), .DEPTH(16), .GAP_CYCLES(3)) u_gap (
      .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_last(b_wr_last),
      .wr_full(b_wr_full), .data_out(b_data_out), .end_out(b_end_out), .valid_out(b_valid_out),
      .ready_out(b_ready_out)
`ifdef AVST_TX_STATS_EN
      , .tx_pkt_cnt(b_tx_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_beat(input logic [7:0] d, input logic l);
      wr_en   = 1'b1;
      wr_data = d;
      wr_last = l;
      exp_q.push_back({l, d});
      tick();
   endtask

   task automatic check_out(input string tag, input logic v, input logic e, input logic [7:0] d);
      check(tag, 32'({valid_out, end_out, data_out}), 32'({v, e, d}));
   endtask

   task automatic check_b(input string tag, input logic v, input logic e, input logic [7:0] d);
      check(tag, 32'({b_valid_out, b_end_out, b_data_out}), 32'({v, e, d}));
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic drain(input int max_cyc, input logic rand_rdy);
      for (int i = 0; i < max_cyc && got_q.size() < exp_q.size(); i++) begin
         ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #2 reset = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // Transfer recorder and hold-stability check under backpressure.
   always @(negedge clk) begin
      if (!reset) begin
         hold_pend <= 1'b0;
      end else begin
         if (hold_pend)
            check("hold_stable", 32'({valid_out, end_out, data_out}), 32'({1'b1, held}));
         if (valid_out && ready_out) got_q.push_back({end_out, data_out});
         hold_pend <= valid_out && !ready_out;
         held      <= {end_out, data_out};
      end
   end

   initial begin
      int np, plen;
      reset = 1'b1;
      wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; ready_out = 1'b0;
      b_wr_en = 1'b0; b_wr_data = '0; b_wr_last = 1'b0; b_ready_out = 1'b0;
      #3 reset = 1'b0;
      #1;
      check_out("rst_out", 1'b0, 1'b0, 8'h00);
      check("rst_full", 32'(wr_full), 32'(0));
      check_b("rst_out_b", 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Test 1: latency and consecutive beats
      ready_out = 1'b1;
      wr_beat(8'h11, 1'b0);
      wr_beat(8'h22, 1'b0);
      wr_beat(8'h33, 1'b1);
      wr_en = 1'b0;
      check_out("t1_lat0", 1'b0, 1'b0, 8'h00);
      tick(); check("t1_lat1", 32'(valid_out), 32'(0));
      tick(); check_out("t1_b0", 1'b1, 1'b0, 8'h11);
      tick(); check_out("t1_b1", 1'b1, 1'b0, 8'h22);
      tick(); check_out("t1_b2", 1'b1, 1'b1, 8'h33);
      tick(); check("t1_idle", 32'(valid_out), 32'(0));
      cmp_stream("t1");

      // Test 2: backpressure 1,0,0,1
      ready_out = 1'b0;
      wr_beat(8'hA0, 1'b0);
      wr_beat(8'hA1, 1'b0);
      wr_beat(8'hA2, 1'b0);
      wr_beat(8'hA3, 1'b1);
      wr_en = 1'b0;
      tick(); tick();
      check_out("t2_b0", 1'b1, 1'b0, 8'hA0);
      ready_out = 1'b1; tick(); check_out("t2_r1", 1'b1, 1'b0, 8'hA1);
      ready_out = 1'b0; tick(); check_out("t2_r0a", 1'b1, 1'b0, 8'hA1);
      ready_out = 1'b0; tick(); check_out("t2_r0b", 1'b1, 1'b0, 8'hA1);
      ready_out = 1'b1; tick(); check_out("t2_r1b", 1'b1, 1'b0, 8'hA2);
      tick(); check_out("t2_b3", 1'b1, 1'b1, 8'hA3);
      tick(); check("t2_idle", 32'(valid_out), 32'(0));
      cmp_stream("t2");

      // Test 3a: back-to-back with no gap
      ready_out = 1'b0;
      wr_beat(8'h81, 1'b0);
      wr_beat(8'h82, 1'b1);
      wr_beat(8'h91, 1'b0);
      wr_beat(8'h92, 1'b1);
      wr_en = 1'b0;
      tick(); tick();
      check_out("b2b_0", 1'b1, 1'b0, 8'h81);
      ready_out = 1'b1;
      tick(); check_out("b2b_1", 1'b1, 1'b1, 8'h82);
      tick(); check_out("b2b_2", 1'b1, 1'b0, 8'h91);
      tick(); check_out("b2b_3", 1'b1, 1'b1, 8'h92);
      tick(); check("b2b_idle", 32'(valid_out), 32'(0));
      cmp_stream("b2b");

      // Test 3b: GAP_CYCLES=3 instance
      b_wr_en = 1'b1;
      b_wr_data = 8'h61; b_wr_last = 1'b0; tick();
      b_wr_data = 8'h62; b_wr_last = 1'b1; tick();
      b_wr_data = 8'h71; b_wr_last = 1'b0; tick();
      b_wr_data = 8'h72; b_wr_last = 1'b1; tick();
      b_wr_en = 1'b0;
      tick(); tick(); tick();
      check_b("gap_p1a", 1'b1, 1'b0, 8'h61);
      b_ready_out = 1'b1;
      tick(); check_b("gap_p1b", 1'b1, 1'b1, 8'h62);
      tick(); check("gap_z1", 32'(b_valid_out), 32'(0));
      tick(); check("gap_z2", 32'(b_valid_out), 32'(0));
      tick(); check("gap_z3", 32'(b_valid_out), 32'(0));
      tick(); check_b("gap_p2a", 1'b1, 1'b0, 8'h71);
      tick(); check_b("gap_p2b", 1'b1, 1'b1, 8'h72);
      tick(); check("gap_after", 32'(b_valid_out), 32'(0));
      b_ready_out = 1'b0;

      // Test 4: fill without last, overflow ignored, cut-through drain
      ready_out = 1'b0;
      for (int i = 0; i < 16; i++) wr_beat(8'(8'h40 + i), 1'b0);
      check("t4_full", 32'(wr_full), 32'(1));
      check("t4_novld", 32'(valid_out), 32'(0));
      wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      check("t4_full17", 32'(wr_full), 32'(1));
      tick();
      check("t4_unfull", 32'(wr_full), 32'(0));
      check_out("t4_head", 1'b1, 1'b0, 8'h40);
      ready_out = 1'b1;
      for (int i = 0; i < 40 && got_q.size() < 16; i++) tick();
      check("t4_empty_wait", 32'(valid_out), 32'(0));
      wr_beat(8'h5F, 1'b1);
      wr_en = 1'b0;
      tick(); check_out("t4_tail", 1'b1, 1'b1, 8'h5F);
      tick(); check("t4_idle", 32'(valid_out), 32'(0));
      cmp_stream("t4");

      // Test 5: reset while beat 2 of 4 is presented
      ready_out = 1'b1;
      wr_beat(8'hB0, 1'b0);
      wr_beat(8'hB1, 1'b0);
      wr_beat(8'hB2, 1'b0);
      wr_beat(8'hB3, 1'b1);
      wr_en = 1'b0;
      tick(); tick();
      tick(); check_out("t5_b1", 1'b1, 1'b0, 8'hB1);
      #2 reset = 1'b0;
      #1 check_out("t5_rst", 1'b0, 1'b0, 8'h00);
      exp_q.delete();
      exp_q.push_back({1'b0, 8'hB0});
      tick(); tick();
      @(negedge clk);
      reset = 1'b1;
      repeat (6) tick();
      check("t5_quiet", 32'(got_q.size()), 32'(1));
      check("t5_full", 32'(wr_full), 32'(0));
      wr_beat(8'hC0, 1'b0);
      wr_beat(8'hC1, 1'b1);
      wr_en = 1'b0;
      drain(20, 1'b0);
      cmp_stream("t5");

      // Randomized packets with random backpressure
      for (int r = 0; r < 8; r++) begin
         np = $urandom_range(1, 4);
         for (int p = 0; p < np; p++) begin
            plen = $urandom_range(1, 4);
            for (int b = 0; b < plen; b++) begin
               ready_out = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) begin
                  wr_en = 1'b0;
                  tick();
               end
               wr_beat(8'($urandom_range(0, 255)), (b == plen - 1));
            end
         end
         wr_en = 1'b0;
         drain(300, 1'b1);
         check("rnd_idle", 32'(valid_out), 32'(0));
         cmp_stream("rnd");
      end

`ifdef AVST_TX_STATS_EN
      reset_pulse();
      check("st_clr0", 32'(tx_cnt), 32'(0));
      ready_out = 1'b1;
      for (int p = 0; p < 5; p++) begin
         wr_beat(8'(p), 1'b0);
         wr_beat(8'(p + 8'h10), 1'b1);
         wr_en = 1'b0;
         drain(20, 1'b0);
      end
      cmp_stream("st");
      check("st_cnt5", 32'(tx_cnt), 32'(5));
      reset_pulse();
      check("st_clr1", 32'(tx_cnt), 32'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
